// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer; filters traps/interrupts against CP0 status and drives CP0 and fetch redirect.
// Optional timer interrupt source enabled by defining EXC_TIMER_EN.
module exc_ctrl #(
  parameter logic [31:0] VEC_ADDR  = 32'h00400004,
  parameter logic [4:0]  CAUSE_SYS = 5'b01000,
  parameter logic [4:0]  CAUSE_BRK = 5'b01001,
  parameter logic [4:0]  CAUSE_TEQ = 5'b01101,
  parameter logic [4:0]  CAUSE_INT = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] pc_in,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        eret_req,
  input  logic        intr,
`ifdef EXC_TIMER_EN
  input  logic        timer_int,
`endif
  input  logic [31:0] status,
  input  logic [31:0] exc_addr,
  output logic        exception,
  output logic [4:0]  cause,
  output logic [31:0] epc,
  output logic        eret,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall
);
  typedef enum logic [1:0] {IDLE, EXC, VEC, RET} state_e;
  state_e      state_q, state_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        int_pend_q, int_pend_d;
  logic        go, ie, t_teq, t_brk, t_sys, trap, t_int, t_tmr, take, do_ret;
  logic        unused_status;
  assign unused_status = ^status[31:5];
  assign go     = state_q == IDLE && instr_valid && !rst;
  assign ie     = status[0];
  assign t_teq  = go & ie & status[3] & teq_req;
  assign t_brk  = go & ie & status[2] & break_req;
  assign t_sys  = go & ie & status[1] & syscall_req;
  assign trap   = t_teq | t_brk | t_sys;
  assign do_ret = go & eret_req & ~trap;
  assign t_int  = go & ie & status[4] & int_pend_q & ~trap & ~eret_req;
`ifdef EXC_TIMER_EN
  logic tmr_pend_q, tmr_pend_d;
  // Timer ranks below the external interrupt and shares its enable bit.
  assign t_tmr      = go & ie & status[4] & tmr_pend_q & ~trap & ~eret_req & ~int_pend_q;
  assign tmr_pend_d = (tmr_pend_q & ~t_tmr) | timer_int;
  always_ff @(posedge clk) begin
    if (rst) tmr_pend_q <= 1'b0;
    else     tmr_pend_q <= tmr_pend_d;
  end
`else
  assign t_tmr = 1'b0;
`endif
  assign take = trap | t_int | t_tmr;
  always_comb begin
    state_d    = state_q == EXC ? VEC : take ? EXC : do_ret ? RET : IDLE;
    cause_d    = !take ? cause_q : t_teq ? CAUSE_TEQ : t_brk ? CAUSE_BRK :
                 t_sys ? CAUSE_SYS : t_int ? CAUSE_INT : 5'b00001;
    epc_d      = take ? pc_in : epc_q;
    int_pend_d = (int_pend_q & ~t_int) | intr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cause_q    <= 5'b0;
      epc_q      <= 32'b0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      int_pend_q <= int_pend_d;
    end
  end
  assign exception   = state_q == EXC;
  assign cause       = exception ? cause_q : 5'b0;
  assign epc         = exception ? epc_q : 32'b0;
  assign eret        = state_q == RET;
  assign redirect    = state_q == VEC || state_q == RET;
  assign redirect_pc = state_q == VEC ? VEC_ADDR : state_q == RET ? exc_addr : 32'b0;
  assign flush       = redirect;
  assign stall       = state_q != IDLE || take || do_ret;
endmodule
